// File: rtl/pio_pkg.sv
// Shared constants for the pio_gpio_ctrl Avalon-MM GPIO slave:
// register word addresses and edge-capture mode encodings.
package pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_INPUT   = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync.sv
// WIDTH x STAGES flop-chain synchroniser for asynchronous inputs.
// Every stage resets to zero.
module pio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/pio_gpio_ctrl.sv
// Avalon-MM GPIO slave: output register with atomic set/clear, synchronised
// input, per-bit edge capture with maskable level irq, and a write strobe.
module pio_gpio_ctrl
    import pio_pkg::*;
#(
    parameter int               OUT_W       = 8,
    parameter int               IN_W        = 8,
    parameter logic [OUT_W-1:0] OUT_RESET   = '0,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [IN_W-1:0]  in_port,
    output logic [OUT_W-1:0] out_port,
    output logic             out_strobe,
    output logic             irq
);

    // Avalon-MM slave: a write is accepted in any cycle with chipselect high
    // and write_n low (no wait states); reads are combinational, latency 0.
    logic wr_en;
    assign wr_en = chipselect && !write_n;

    logic [OUT_W-1:0] out_q, out_d;
    logic             strobe_q, strobe_d;
    logic [IN_W-1:0]  mask_q, mask_d;
    logic [IN_W-1:0]  edge_q, edge_d;
    logic [IN_W-1:0]  prev_q, prev_d;
    logic [IN_W-1:0]  sync_w;
    logic [IN_W-1:0]  edge_det;
    logic [31:0]      rdata;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    pio_sync #(
        .WIDTH  (IN_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (in_port),
        .dout    (sync_w)
    );

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_det = sync_w & ~prev_q;
            EDGE_FALL: edge_det = ~sync_w & prev_q;
            default:   edge_det = sync_w ^ prev_q;
        endcase
    end

    always_comb begin
        out_d    = out_q;
        mask_d   = mask_q;
        edge_d   = edge_q;
        prev_d   = sync_w;
        strobe_d = 1'b0;
        if (wr_en) begin
            case (address)
                ADDR_DATA: begin
                    out_d    = writedata[OUT_W-1:0];
                    strobe_d = 1'b1;
                end
                ADDR_OUTSET: begin
                    out_d    = out_q | writedata[OUT_W-1:0];
                    strobe_d = 1'b1;
                end
                ADDR_OUTCLR: begin
                    out_d    = out_q & ~writedata[OUT_W-1:0];
                    strobe_d = 1'b1;
                end
                ADDR_IRQMASK: mask_d = writedata[IN_W-1:0];
                ADDR_EDGE:    edge_d = edge_q & ~writedata[IN_W-1:0];
                default: ;
            endcase
        end
        // A fresh edge is OR-ed in after the clear, so it survives a same-cycle W1C.
        edge_d = edge_d | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q    <= OUT_RESET;
            mask_q   <= '0;
            edge_q   <= '0;
            prev_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            prev_q   <= prev_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (address)
            ADDR_DATA:    rdata[OUT_W-1:0] = out_q;
            ADDR_INPUT:   rdata[IN_W-1:0]  = sync_w;
            ADDR_IRQMASK: rdata[IN_W-1:0]  = mask_q;
            ADDR_EDGE:    rdata[IN_W-1:0]  = edge_q;
            default: ;
        endcase
    end

    assign readdata   = rdata;
    assign out_port   = out_q;
    assign out_strobe = strobe_q;
    assign irq        = |(edge_q & mask_q);

endmodule

// File: tb/tb_pio_gpio_ctrl.sv
// Directed bench for pio_gpio_ctrl: a rising-edge instance (OUT_RESET=A5) and
// an any-edge instance share the bus; expected values are hand-computed.
module tb_pio_gpio_ctrl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        cs0, cs1;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rdata0, rdata1;
    logic [7:0]  in0, in1;
    logic [7:0]  out0, out1;
    logic        strb0, strb1;
    logic        irq0, irq1;

    int n_checks = 0;
    int n_errors = 0;

    pio_gpio_ctrl #(
        .OUT_W(8), .IN_W(8), .OUT_RESET(8'hA5), .SYNC_STAGES(2), .EDGE_TYPE(0)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
        .write_n(write_n), .writedata(writedata), .readdata(rdata0),
        .in_port(in0), .out_port(out0), .out_strobe(strb0), .irq(irq0)
    );

    pio_gpio_ctrl #(
        .OUT_W(8), .IN_W(8), .OUT_RESET(8'h00), .SYNC_STAGES(2), .EDGE_TYPE(2)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
        .write_n(write_n), .writedata(writedata), .readdata(rdata1),
        .in_port(in1), .out_port(out1), .out_strobe(strb1), .irq(irq1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drives one write cycle, returns at the next negedge.
    task automatic bus_write(input bit which, input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        cs0       = (which == 1'b0);
        cs1       = (which == 1'b1);
        write_n   = 1'b0;
        @(negedge clk);
        cs0     = 1'b0;
        cs1     = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic read_check(input bit which, input logic [2:0] a, input string tag,
                              input logic [31:0] exp);
        address = a;
        #1;
        check(tag, which ? rdata1 : rdata0, exp);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = 3'd0;
        cs0       = 1'b0;
        cs1       = 1'b0;
        write_n   = 1'b1;
        writedata = '0;
        in0       = '0;
        in1       = '0;
        #12 reset_n = 1'b1;
        @(negedge clk);

        // reset state
        check("rst_out", {24'd0, out0}, 32'hA5);
        check("rst_strobe", {31'd0, strb0}, 32'd0);
        check("rst_irq", {31'd0, irq0}, 32'd0);
        read_check(1'b0, 3'd0, "rst_rd_data", 32'h0000_00A5);
        read_check(1'b0, 3'd3, "rst_rd_edge", 32'd0);

        // DATA / OUTSET / OUTCLR with one strobe per write
        @(negedge clk);
        bus_write(1'b0, 3'd0, 32'h0000_003C);
        check("data_out", {24'd0, out0}, 32'h3C);
        check("data_strobe", {31'd0, strb0}, 32'd1);
        @(negedge clk);
        check("data_strobe_off", {31'd0, strb0}, 32'd0);
        bus_write(1'b0, 3'd4, 32'hFFFF_FF81);
        check("set_out", {24'd0, out0}, 32'hBD);
        check("set_strobe", {31'd0, strb0}, 32'd1);
        @(negedge clk);
        check("set_strobe_off", {31'd0, strb0}, 32'd0);
        bus_write(1'b0, 3'd5, 32'h0000_000C);
        check("clr_out", {24'd0, out0}, 32'hB1);
        check("clr_strobe", {31'd0, strb0}, 32'd1);
        read_check(1'b0, 3'd0, "clr_rd_data", 32'h0000_00B1);
        @(negedge clk);
        check("clr_strobe_off", {31'd0, strb0}, 32'd0);

        // unchanged value still strobes; reserved write neither changes nor strobes
        bus_write(1'b0, 3'd4, 32'h0000_0001);
        check("nochg_strobe", {31'd0, strb0}, 32'd1);
        check("nochg_out", {24'd0, out0}, 32'hB1);
        @(negedge clk);
        bus_write(1'b0, 3'd6, 32'h0000_00FF);
        check("rsv_wr_out", {24'd0, out0}, 32'hB1);
        check("rsv_wr_strobe", {31'd0, strb0}, 32'd0);
        read_check(1'b0, 3'd4, "rd_outset_zero", 32'd0);

        // rising edge on bit 0 with mask 0x01
        @(negedge clk);
        bus_write(1'b0, 3'd2, 32'h0000_0001);
        read_check(1'b0, 3'd2, "rd_mask", 32'h01);
        @(negedge clk);
        in0 = 8'h01;
        @(negedge clk);
        read_check(1'b0, 3'd1, "input_t1", 32'h00);
        @(negedge clk);
        read_check(1'b0, 3'd1, "input_t2", 32'h01);
        read_check(1'b0, 3'd3, "edge_t2", 32'h00);
        check("irq_t2", {31'd0, irq0}, 32'd0);
        @(negedge clk);
        read_check(1'b0, 3'd3, "edge_t3", 32'h01);
        check("irq_t3", {31'd0, irq0}, 32'd1);
        read_check(1'b0, 3'd3, "edge_read_no_clear", 32'h01);
        @(negedge clk);
        bus_write(1'b0, 3'd3, 32'h0000_0001);
        read_check(1'b0, 3'd3, "edge_w1c", 32'h00);
        check("irq_w1c", {31'd0, irq0}, 32'd0);

        // W1C of bit 2 in the cycle its new edge is detected; bit 1 also rises
        @(negedge clk);
        in0 = 8'h07;
        wait_cycles(2);
        bus_write(1'b0, 3'd3, 32'h0000_0004);
        read_check(1'b0, 3'd3, "edge_clr_vs_new", 32'h06);

        // any-edge instance: two toggles of bit 1 with mask 0
        @(negedge clk);
        in1 = 8'h02;
        wait_cycles(4);
        in1 = 8'h00;
        wait_cycles(4);
        read_check(1'b1, 3'd3, "any_edge", 32'h02);
        check("any_irq_masked", {31'd0, irq1}, 32'd0);
        @(negedge clk);
        bus_write(1'b1, 3'd2, 32'h0000_0002);
        check("any_irq_unmasked", {31'd0, irq1}, 32'd1);
        check("dut0_irq_untouched", {31'd0, irq0}, 32'd0);

        // build state then reset mid-strobe
        @(negedge clk);
        in0 = 8'h0F;
        wait_cycles(3);
        bus_write(1'b0, 3'd2, 32'h0000_000F);
        read_check(1'b0, 3'd3, "pre_rst_edge", 32'h0E);
        check("pre_rst_irq", {31'd0, irq0}, 32'd1);
        @(negedge clk);
        bus_write(1'b0, 3'd0, 32'h0000_00FF);
        check("pre_rst_out", {24'd0, out0}, 32'hFF);
        check("pre_rst_strobe", {31'd0, strb0}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_out", {24'd0, out0}, 32'hA5);
        check("mid_rst_strobe", {31'd0, strb0}, 32'd0);
        check("mid_rst_irq0", {31'd0, irq0}, 32'd0);
        check("mid_rst_irq1", {31'd0, irq1}, 32'd0);
        read_check(1'b0, 3'd3, "mid_rst_edge", 32'd0);
        read_check(1'b0, 3'd2, "mid_rst_mask", 32'd0);
        read_check(1'b0, 3'd1, "mid_rst_input", 32'd0);
        read_check(1'b0, 3'd6, "rd_addr6", 32'd0);
        read_check(1'b0, 3'd7, "rd_addr7", 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // inputs held high through reset show as rising edges afterwards
        wait_cycles(2);
        read_check(1'b0, 3'd3, "post_rst_edge_t2", 32'h00);
        read_check(1'b0, 3'd1, "post_rst_input_t2", 32'h0F);
        @(negedge clk);
        read_check(1'b0, 3'd3, "post_rst_edge_t3", 32'h0F);
        check("post_rst_irq_masked", {31'd0, irq0}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
